// File: rtl/rx_data_fifo.sv
// Receive-side byte queue behind the UART receiver controller: captures payloads on
// load_buffer, presents the oldest byte first-word fall-through, flags dropped packets.
module rx_data_fifo #(
   parameter  int DATA_WIDTH = 8,
   parameter  int DEPTH      = 4,
   localparam int ADDR_BITS  = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  load_buffer,
   input  logic [DATA_WIDTH-1:0] packet_data,
   input  logic                  data_read,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  data_ready,
   output logic                  full,
   output logic [ADDR_BITS:0]    fifo_count,
   output logic                  overrun_error
);

   localparam logic [ADDR_BITS:0] FULL_CNT = DEPTH[ADDR_BITS:0];

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_BITS-1:0]  wr_ptr;
   logic [ADDR_BITS-1:0]  rd_ptr;
   logic [ADDR_BITS:0]    count;
   logic                  ovr;
   logic                  rd_acc;
   logic                  wr_acc;
   logic                  drop;

   // A read on a full queue frees the slot the same-cycle write lands in.
   always_comb begin
      rd_acc = data_read && (count != '0);
      wr_acc = load_buffer && ((count != FULL_CNT) || rd_acc);
      drop   = load_buffer && !wr_acc;
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= packet_data;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovr    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         if (wr_acc && !rd_acc)      count <= count + 1'b1;
         else if (rd_acc && !wr_acc) count <= count - 1'b1;
         if (drop)        ovr <= 1'b1;
         else if (rd_acc) ovr <= 1'b0;
      end
   end

   always_comb begin
      data_ready    = (count != '0);
      full          = (count == FULL_CNT);
      fifo_count    = count;
      overrun_error = ovr;
      rx_data       = (count != '0) ? mem[rd_ptr] : '1;
   end

endmodule

// File: tb/tb_rx_data_fifo.sv
// Directed and randomized checks of rx_data_fifo against a queue-based reference model.
module tb_rx_data_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int AB    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          load_buffer = 1'b0;
   logic [DW-1:0] packet_data = '0;
   logic          data_read = 1'b0;
   logic [DW-1:0] rx_data;
   logic          data_ready;
   logic          full;
   logic [AB:0]   fifo_count;
   logic          overrun_error;

   int n_assert = 0;
   int n_fail   = 0;

   logic [DW-1:0] q[$];
   bit            m_ovr = 1'b0;

   rx_data_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .n_rst(n_rst), .load_buffer(load_buffer), .packet_data(packet_data),
      .data_read(data_read), .rx_data(rx_data), .data_ready(data_ready), .full(full),
      .fifo_count(fifo_count), .overrun_error(overrun_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      logic [DW-1:0] exp_rx;
      exp_rx = (q.size() != 0) ? q[0] : 8'hFF;
      chk({tag, ".data_ready"}, 32'(data_ready), 32'(q.size() != 0));
      chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
      chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(q.size()));
      chk({tag, ".overrun"}, 32'(overrun_error), 32'(m_ovr));
      chk({tag, ".rx_data"}, 32'(rx_data), 32'(exp_rx));
   endtask

   // Drive one cycle of inputs, advance the model by the queue rules, check after the edge.
   task automatic step(input logic l, input logic [DW-1:0] d, input logic r, input string tag);
      bit rd, wr;
      load_buffer = l; packet_data = d; data_read = r;
      rd = r && (q.size() != 0);
      wr = l && ((q.size() < DEPTH) || rd);
      if (l && !wr) m_ovr = 1'b1;
      else if (rd)  m_ovr = 1'b0;
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(d);
      @(posedge clk); #1;
      load_buffer = 1'b0; data_read = 1'b0;
      chk_all(tag);
   endtask

   initial begin
      logic [DW-1:0] seq [4];
      #2 chk_all("reset_async");
      @(negedge clk) n_rst = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, "idle");
      chk("idle.rx_ff", 32'(rx_data), 32'h0000_00FF);

      step(1'b1, 8'hA5, 1'b0, "single_load");
      chk("single.rx", 32'(rx_data), 32'h0000_00A5);
      step(1'b0, '0, 1'b1, "single_read");
      step(1'b0, '0, 1'b1, "read_empty");

      for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, "fill");
      chk("fill.full", 32'(full), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         chk("drain.order", 32'(rx_data), 32'(i));
         step(1'b0, '0, 1'b1, "drain");
      end

      for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, "refill");
      step(1'b1, 8'h55, 1'b0, "overrun_set");
      chk("overrun.flag", 32'(overrun_error), 32'd1);
      step(1'b0, '0, 1'b1, "overrun_clear");
      chk("overrun.rx02", 32'(rx_data), 32'h0000_0002);
      step(1'b1, 8'h01, 1'b0, "refill2");
      chk("refill2.full", 32'(full), 32'd1);
      step(1'b1, 8'h77, 1'b1, "full_load_read");
      chk("flr.overrun", 32'(overrun_error), 32'd0);
      seq = '{8'h03, 8'h04, 8'h01, 8'h77};
      for (int i = 0; i < 4; i++) begin
         chk("flr.order", 32'(rx_data), 32'(seq[i]));
         step(1'b0, '0, 1'b1, "flr_drain");
      end

      step(1'b1, 8'h10, 1'b1, "empty_load_read");
      chk("elr.count", 32'(fifo_count), 32'd1);
      step(1'b0, '0, 1'b1, "elr_drain");

      for (int i = 0; i < 6; i++) begin
         step(1'b1, 8'(8'hC0 + i), 1'b0, "wrap_w");
         chk("wrap.rx", 32'(rx_data), 32'(8'hC0 + i));
         step(1'b0, '0, 1'b1, "wrap_r");
      end

      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, "pre_rst");
      #3 n_rst = 1'b0;
      q.delete(); m_ovr = 1'b0;
      #1 chk_all("mid_reset");
      @(negedge clk) n_rst = 1'b1;
      @(posedge clk); #1;
      chk_all("post_reset");
      step(1'b1, 8'h9C, 1'b0, "post_rst_load");
      chk("post_rst.rx", 32'(rx_data), 32'h0000_009C);
      step(1'b0, '0, 1'b1, "post_rst_read");

      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 45), "random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rx_data_fifo.md
Name: rx_data_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver controller.
- Captures each completed packet's data bits on the controller's one-cycle `load_buffer` pulse.
- Queues up to DEPTH bytes and presents the oldest byte to the host with a ready/read handshake.
- Raises a sticky overrun flag when a packet arrives while the queue is full.

Parameters:
- DATA_WIDTH, 8, width of one received packet payload.
- DEPTH, 4, number of entries; power of two, minimum 2.
- ADDR_BITS, log2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- n_rst  input  1  asynchronous active-low reset
- load_buffer  input  1  one-cycle pulse from receiver controller: packet_data valid, store it
- packet_data  input  DATA_WIDTH  payload bits from receive shift register, stable while load_buffer high
- data_read  input  1  one-cycle pulse from host: head byte consumed
- rx_data  output  DATA_WIDTH  oldest stored byte (first-word fall-through)
- data_ready  output  1  high when at least one byte is stored
- full  output  1  high when DEPTH bytes are stored
- fifo_count  output  ADDR_BITS+1  number of stored bytes, 0..DEPTH
- overrun_error  output  1  sticky: a packet was dropped because the queue was full

Behaviour:
- Reset is asynchronous, active-low, on clock clk.
  - Pointers = 0, count = 0, data_ready = 0, full = 0, fifo_count = 0, overrun_error = 0, rx_data = all ones (8'hFF, idle-line value).
  - Storage array is not required to reset.
- Storage and pointers:
  - Circular storage with wr_ptr and rd_ptr, each ADDR_BITS wide; both wrap from DEPTH-1 to 0 naturally.
  - A registered count (ADDR_BITS+1 bits) disambiguates full from empty.
- Write accept: load_buffer=1 and (count<DEPTH, or data_read accepted in the same cycle).
  - Stores packet_data at wr_ptr and increments wr_ptr.
- Read accept: data_read=1 and count>0. Increments rd_ptr.
  - data_read while empty is ignored: no pointer move, no error.
- Count update on each edge:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on both, or on neither.
- Simultaneous load and read:
  - When full: read frees a slot, write is accepted, count stays DEPTH, no overrun.
  - When empty: write accepted, read ignored (data was not yet ready); count becomes 1.
- Overrun:
  - load_buffer=1 while count==DEPTH with no accepted read in that cycle: packet_data discarded, storage and pointers unchanged, overrun_error set on that edge.
  - overrun_error stays set until an accepted read; it clears on the edge of that read.
  - Set takes priority over clear; in practice they cannot coincide.
- Outputs (all derived from registered state, no combinational path from inputs):
  - data_ready = (count != 0).
  - full = (count == DEPTH).
  - fifo_count = count.
  - rx_data = storage[rd_ptr] when count != 0, else all ones.
- Latency:
  - A byte written on edge k appears on rx_data, with data_ready=1, immediately after edge k (if the queue was empty).
  - After an accepted read on edge k, rx_data shows the next entry, or all ones if empty, immediately after edge k.
- Framing-error packets: the controller never pulses load_buffer for them, so nothing is stored; no framing logic lives in this block.
- load_buffer held high for N cycles is treated as N writes; the controller guarantees single-cycle pulses.
- Reset asserted mid-operation: all contents are discarded and outputs return to reset values asynchronously, regardless of clk.

Test Plan:
- Reset then idle 10 cycles -> data_ready=0, full=0, fifo_count=0, overrun_error=0, rx_data=8'hFF.
- Single load, packet_data=8'hA5 -> next cycle data_ready=1, rx_data=8'hA5, fifo_count=1. Then data_read pulse -> data_ready=0, rx_data=8'hFF, fifo_count=0.
- Load 8'h01, 8'h02, 8'h03, 8'h04 (DEPTH=4) -> full=1, fifo_count=4. Four reads return 01, 02, 03, 04 in order; full drops after the first read.
- Full queue, load 8'h55 with no read -> overrun_error=1, fifo_count=4, contents unchanged, 8'h55 never read out. Next data_read -> overrun_error=0, rx_data=8'h02.
- Full queue, load 8'h77 and data_read in the same cycle -> overrun_error stays 0, fifo_count=4, read order 02, 03, 04, 77.
- Six write/read pairs to exercise pointer wrap-around -> data order preserved across wrap. Separately, assert n_rst with 3 entries queued -> all outputs back to reset values immediately, a subsequent load reads back correctly.
